// File: rtl/register_file_mp.sv
// Multi-port register file with two write ports, optional write-to-read bypass,
// synchronous clear of the whole array and a per-register pending scoreboard.
module register_file_mp #(
  parameter int width        = 32,
  parameter int addresswidth = 5,
  parameter int depth        = 2**addresswidth,
  parameter int readports    = 2,
  parameter bit zeroreg      = 1'b1,
  parameter bit bypass       = 1'b1
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic [readports*addresswidth-1:0] ReadRegister,
  output logic [readports*width-1:0]        ReadData,
  output logic [readports-1:0]              ReadPending,
  input  logic [addresswidth-1:0]           WriteRegisterA,
  input  logic [width-1:0]                  WriteDataA,
  input  logic                              RegWriteA,
  input  logic [addresswidth-1:0]           WriteRegisterB,
  input  logic [width-1:0]                  WriteDataB,
  input  logic                              RegWriteB,
  input  logic [addresswidth-1:0]           ReserveRegister,
  input  logic                              Reserve
);

  localparam int idx_w = (depth > 1) ? $clog2(depth) : 1;

  logic [width-1:0] regs_q [depth];
  logic [width-1:0] regs_d [depth];
  logic [depth-1:0] pending_q;
  logic [depth-1:0] pending_d;

  // Addresses at or beyond depth map to no register at all.
  function automatic logic in_range(input logic [addresswidth-1:0] a);
    return ({1'b0, a} < (addresswidth+1)'(depth));
  endfunction

  function automatic logic is_zero_reg(input logic [addresswidth-1:0] a);
    return zeroreg && (a == '0);
  endfunction

  logic             wr_a_ok, wr_b_ok, rsv_ok;
  logic [idx_w-1:0] wa_idx, wb_idx, rv_idx;

  assign wr_a_ok = RegWriteA && in_range(WriteRegisterA) && !is_zero_reg(WriteRegisterA);
  assign wr_b_ok = RegWriteB && in_range(WriteRegisterB) && !is_zero_reg(WriteRegisterB);
  assign rsv_ok  = Reserve && in_range(ReserveRegister) && !is_zero_reg(ReserveRegister);
  assign wa_idx  = WriteRegisterA[idx_w-1:0];
  assign wb_idx  = WriteRegisterB[idx_w-1:0];
  assign rv_idx  = ReserveRegister[idx_w-1:0];

  // B is applied after A so it wins a same-address collision; a reservation is
  // applied last because it marks a newer producer than the completing write.
  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    if (wr_a_ok) begin
      regs_d[wa_idx]    = WriteDataA;
      pending_d[wa_idx] = 1'b0;
    end
    if (wr_b_ok) begin
      regs_d[wb_idx]    = WriteDataB;
      pending_d[wb_idx] = 1'b0;
    end
    if (rsv_ok) begin
      pending_d[rv_idx] = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pending_q <= '0;
      for (int i = 0; i < depth; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      regs_q    <= regs_d;
    end
  end

  for (genvar gi = 0; gi < readports; gi++) begin : g_read
    logic [addresswidth-1:0] ra;
    logic [idx_w-1:0]        ri;
    logic                    ok, hit_a, hit_b;
    logic [width-1:0]        rdata;
    logic                    rpend;

    assign ra    = ReadRegister[gi*addresswidth +: addresswidth];
    assign ri    = ra[idx_w-1:0];
    assign ok    = in_range(ra) && !is_zero_reg(ra);
    // Forwarding is suppressed during reset so reads reflect stored state only.
    assign hit_a = bypass && !Reset && wr_a_ok && (WriteRegisterA == ra);
    assign hit_b = bypass && !Reset && wr_b_ok && (WriteRegisterB == ra);

    always_comb begin
      rdata = '0;
      rpend = 1'b0;
      if (ok) begin
        if (hit_b) begin
          rdata = WriteDataB;
        end else if (hit_a) begin
          rdata = WriteDataA;
        end else begin
          rdata = regs_q[ri];
          rpend = pending_q[ri];
        end
      end
    end

    assign ReadData[gi*width +: width] = rdata;
    assign ReadPending[gi]             = rpend;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a default instance (bypass, zero register) and a
// 4-port, depth-16 instance without bypass or zero register, both scoreboarded.
module tb_register_file_mp;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  wra, wrb, resr;
  logic [31:0] wda, wdb;
  logic        wea, web, res;

  logic [9:0]   rr0;
  logic [63:0]  rd0;
  logic [1:0]   rp0;
  logic [19:0]  rr1;
  logic [127:0] rd1;
  logic [3:0]   rp1;

  register_file_mp dut0 (
    .Clk(clk), .Reset(rst),
    .ReadRegister(rr0), .ReadData(rd0), .ReadPending(rp0),
    .WriteRegisterA(wra), .WriteDataA(wda), .RegWriteA(wea),
    .WriteRegisterB(wrb), .WriteDataB(wdb), .RegWriteB(web),
    .ReserveRegister(resr), .Reserve(res)
  );

  register_file_mp #(
    .width(32), .addresswidth(5), .depth(16), .readports(4),
    .zeroreg(1'b0), .bypass(1'b0)
  ) dut1 (
    .Clk(clk), .Reset(rst),
    .ReadRegister(rr1), .ReadData(rd1), .ReadPending(rp1),
    .WriteRegisterA(wra), .WriteDataA(wda), .RegWriteA(wea),
    .WriteRegisterB(wrb), .WriteDataB(wdb), .RegWriteB(web),
    .ReserveRegister(resr), .Reserve(res)
  );

  // Reference state: index 0 models dut0, index 1 models dut1.
  logic [31:0] mem  [2][32];
  logic        pend [2][32];

  typedef struct {
    string       tag;
    logic [32:0] val;   // {pending, data}
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got pend/data %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] exp_read(input int c, input logic [4:0] a);
    int dep;
    bit zr, byp;
    dep = (c == 0) ? 32 : 16;
    zr  = (c == 0);
    byp = (c == 0);
    if (int'(a) >= dep) return 33'd0;
    if (zr && a == 5'd0) return 33'd0;
    if (byp && !rst) begin
      if (web && wrb == a) return {1'b0, wdb};
      if (wea && wra == a) return {1'b0, wda};
    end
    return {pend[c][a], mem[c][a]};
  endfunction

  task automatic model_step(input int c);
    int dep;
    bit zr;
    dep = (c == 0) ? 32 : 16;
    zr  = (c == 0);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mem[c][i]  = 32'd0;
        pend[c][i] = 1'b0;
      end
    end else begin
      if (wea && int'(wra) < dep && !(zr && wra == 5'd0)) begin
        mem[c][wra] = wda; pend[c][wra] = 1'b0;
      end
      if (web && int'(wrb) < dep && !(zr && wrb == 5'd0)) begin
        mem[c][wrb] = wdb; pend[c][wrb] = 1'b0;
      end
      if (res && int'(resr) < dep && !(zr && resr == 5'd0)) begin
        pend[c][resr] = 1'b1;
      end
    end
  endtask

  task automatic idle();
    rst = 1'b0; wea = 1'b0; web = 1'b0; res = 1'b0;
    wra = 5'd0; wrb = 5'd0; resr = 5'd0; wda = 32'd0; wdb = 32'd0;
  endtask

  // Inputs are already applied; push expectations, check at negedge, advance model at posedge.
  task automatic cycle(input string tag);
    exp_t e;
    for (int p = 0; p < 2; p++) begin
      e.tag = $sformatf("%s d0p%0d", tag, p);
      e.val = exp_read(0, rr0[p*5 +: 5]);
      exp_q.push_back(e);
    end
    for (int p = 0; p < 4; p++) begin
      e.tag = $sformatf("%s d1p%0d", tag, p);
      e.val = exp_read(1, rr1[p*5 +: 5]);
      exp_q.push_back(e);
    end
    @(negedge clk);
    $display("txn %s rst=%0b wA=%0b r%0d wB=%0b r%0d rsv=%0b r%0d rd0=%h rd1=%h",
             tag, rst, wea, wra, web, wrb, res, resr, rd0, rd1);
    for (int p = 0; p < 2; p++) begin
      e = exp_q.pop_front();
      chk(e.tag, {rp0[p], rd0[p*32 +: 32]}, e.val);
    end
    for (int p = 0; p < 4; p++) begin
      e = exp_q.pop_front();
      chk(e.tag, {rp1[p], rd1[p*32 +: 32]}, e.val);
    end
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  initial begin
    idle();
    rr0 = '0;
    rr1 = '0;
    // Bring both arrays out of their unknown power-up state before any check.
    rst = 1'b1;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;

    // Write to r5 in the reset cycle must be discarded.
    rst = 1'b1; wea = 1'b1; wra = 5'd5; wda = 32'hDEADBEEF;
    rr0 = {5'd5, 5'd5}; rr1 = {5'd5, 5'd5, 5'd5, 5'd5};
    cycle("rst_wr5");
    idle();
    for (int i = 0; i < 16; i++) begin
      rr0 = {5'(2*i+1), 5'(2*i)};
      rr1 = {5'(i+16), 5'(31-i), 5'(i), 5'(15-i)};
      cycle($sformatf("rd_all%0d", i));
    end

    // Dual write, different registers.
    wea = 1'b1; wra = 5'd3; wda = 32'h11111111;
    web = 1'b1; wrb = 5'd7; wdb = 32'h22222222;
    rr0 = {5'd7, 5'd3}; rr1 = {5'd7, 5'd3, 5'd7, 5'd3};
    cycle("dual_wr");
    idle();
    cycle("dual_rd");

    // Same-address collision: B wins.
    wea = 1'b1; wra = 5'd9; wda = 32'hAAAA0000;
    web = 1'b1; wrb = 5'd9; wdb = 32'hBBBB0000;
    rr0 = {5'd9, 5'd9}; rr1 = {5'd20, 5'd9, 5'd7, 5'd3};
    cycle("coll_wr");
    idle();
    cycle("coll_rd_4port");

    // Scoreboard on r4.
    rr0 = {5'd4, 5'd4}; rr1 = {5'd4, 5'd4, 5'd9, 5'd4};
    res = 1'b1; resr = 5'd4;
    cycle("rsv4");
    idle();
    cycle("rsv4_rd");
    wea = 1'b1; wra = 5'd4; wda = 32'h5;
    cycle("wr4");
    idle();
    cycle("wr4_rd");
    wea = 1'b1; wra = 5'd4; wda = 32'h5; res = 1'b1; resr = 5'd4;
    cycle("rsv_wr4");
    idle();
    cycle("rsv_wr4_rd");
    web = 1'b1; wrb = 5'd4; wdb = 32'h6;
    cycle("wrB4");
    idle();
    cycle("wrB4_rd");

    // Register 0 behaviour on both configurations.
    rr0 = {5'd0, 5'd0}; rr1 = {5'd0, 5'd1, 5'd0, 5'd0};
    wea = 1'b1; wra = 5'd0; wda = 32'hFFFFFFFF; res = 1'b1; resr = 5'd0;
    cycle("r0_wr");
    idle();
    cycle("r0_rd");

    // Reset while r2 is pending; forwarding must be blocked during reset.
    res = 1'b1; resr = 5'd2;
    rr0 = {5'd2, 5'd3}; rr1 = {5'd2, 5'd3, 5'd7, 5'd0};
    cycle("rsv2");
    idle();
    rst = 1'b1; wea = 1'b1; wra = 5'd2; wda = 32'h1234;
    cycle("rst_mid");
    idle();
    cycle("post_rst");

    // Randomised traffic over a small address window so hits are frequent.
    for (int n = 0; n < 40; n++) begin
      rst  = ($urandom_range(0, 19) == 0);
      wea  = 1'($urandom_range(0, 1));
      web  = 1'($urandom_range(0, 1));
      res  = 1'($urandom_range(0, 1));
      wra  = 5'($urandom_range(0, 7));
      wrb  = 5'($urandom_range(0, 7));
      resr = 5'($urandom_range(0, 7));
      wda  = $urandom;
      wdb  = $urandom;
      for (int p = 0; p < 2; p++) rr0[p*5 +: 5] = 5'($urandom_range(0, 7));
      for (int p = 0; p < 4; p++) rr1[p*5 +: 5] = 5'($urandom_range(0, 18));
      cycle($sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port register file; next generation of the CPU's 2R/1W register file.
- Adds a configurable number of read ports, a second write port, optional write-to-read bypass, synchronous reset of the whole array, and a per-register pending scoreboard.
- Sits between the decode stage (reads, reservations) and the writeback stage (two writes per cycle).

Parameters:
- width, 32, data bits per register.
- addresswidth, 5, register index bits.
- depth, 2**addresswidth, number of registers.
- readports, 2, number of independent read ports (1..8).
- zeroreg, 1: register 0 reads 0 and ignores writes and reservations. 0: register 0 is ordinary.
- bypass, 1: same-cycle write data is forwarded to read ports. 0: reads show stored contents only.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- ReadRegister  in  readports*addresswidth  packed read addresses; port i uses bits [i*addresswidth +: addresswidth].
- ReadData  out  readports*width  packed read data; port i uses bits [i*width +: width].
- ReadPending  out  readports  pending flag for each read port's register.
- WriteRegisterA  in  addresswidth  write port A address.
- WriteDataA  in  width  write port A data.
- RegWriteA  in  1  write port A enable.
- WriteRegisterB  in  addresswidth  write port B address.
- WriteDataB  in  width  write port B data.
- RegWriteB  in  1  write port B enable.
- ReserveRegister  in  addresswidth  register to mark pending.
- Reserve  in  1  reservation enable.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset: on a posedge with Reset=1, all registers clear to 0 and all pending bits clear.
  - Reset has priority over writes and reservations in the same cycle.
  - While Reset=1, bypass is disabled; ReadData and ReadPending show stored state only.
  - After reset, every ReadData is 0 and every ReadPending is 0.
- Reads: combinational, zero latency, with no read-port conflicts.
  - Out-of-range address (index >= depth when depth < 2**addresswidth): ReadData=0, ReadPending=0.
- Writes: take effect at the posedge when RegWriteX=1.
  - If A and B target the same address, B's data is stored; A is dropped.
  - With zeroreg=1, writes to address 0 are ignored.
- Scoreboard: one pending bit per register.
  - On a posedge with Reserve=1, pending[ReserveRegister] is set.
  - On a posedge with an enabled write (A or B) to a register, its pending bit is cleared.
  - Reserve and write to the same register in the same cycle: reserve wins, bit ends at 1 (a new producer was issued).
  - With zeroreg=1, reservation of register 0 is ignored; pending[0] is always 0.
- Bypass (bypass=1, Reset=0): if a read address equals an enabled write address this cycle (excluding reg 0 when zeroreg=1):
  - ReadData returns that write data; B has priority over A.
  - ReadPending is forced to 0.
  - A same-cycle Reserve does not affect reads until the next cycle.
- No bypass (bypass=0): written data is visible on the cycle after the write edge.
- Zero register: with zeroreg=1, ReadData for address 0 is always 0.
- Area: no per-cycle cost beyond muxing; storage is a plain register array, not a RAM macro, because of reset.

Test Plan:
- Reset then read all 32 registers on both ports -> ReadData=0 and ReadPending=0 everywhere; a write of 0xDEADBEEF to r5 asserted together with Reset -> r5 still 0 next cycle.
- Write A r3=0x11111111 and B r7=0x22222222 in one cycle -> next cycle port0@r3=0x11111111, port1@r7=0x22222222; same cycle, bypass=1 -> values already visible; bypass=0 -> old values (0).
- A and B both write r9 (0xAAAA0000 / 0xBBBB0000) -> stored 0xBBBB0000; bypass output in the same cycle also 0xBBBB0000.
- Reserve r4 -> ReadPending for r4=1 next cycle; write r4=0x5 -> pending clears at that edge, and with bypass=1 reads 0x5 and pending 0 in the write cycle; reserve+write r4 together -> pending stays 1, data 0x5.
- zeroreg=1: write r0=0xFFFFFFFF and Reserve r0 -> ReadData@r0=0, ReadPending=0; zeroreg=0 -> r0 reads 0xFFFFFFFF and pending 1.
- readports=4, depth=16 (addresswidth=5): four distinct concurrent reads correct; read address 20 -> 0; Reset asserted mid-sequence with pending r2 set -> all cleared next cycle.
